wide_add_sequencer: RTL and testbench

- Performs one wide unsigned addition of W*WORDS bits (default 128) over several cycles.
- Uses a single shared W-bit carry-select adder, one operand word per cycle, least-significant word first.
- The carry is registered between words, and operands/results use valid/ready handshakes.
- Sits in front of the 32-bit adder datapath so wide arithmetic reuses one adder instead of replicating it.

---
 rtl/wide_add_sequencer_pkg.sv | 17 +
 rtl/add32_cs.sv | 27 ++
 rtl/wide_add_sequencer.sv | 109 ++++++++++
 tb/tb_wide_add_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and constants for the multi-cycle wide adder.
package wide_add_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_W     = 32;
  localparam int DEF_WORDS = 4;

  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/add32_cs.sv
// W-bit carry-select adder: ripple low half, duplicated high half picked by the low carry.
module add32_cs
  import wide_add_sequencer_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int H  = W / 2;
  localparam int HI = W - H;

  logic [H:0]  lo;
  logic [HI:0] hi0;
  logic [HI:0] hi1;

  assign lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
  assign hi0 = {1'b0, a[W-1:H]} + {1'b0, b[W-1:H]};
  assign hi1 = {1'b0, a[W-1:H]} + {1'b0, b[W-1:H]} + {{HI{1'b0}}, 1'b1};

  assign {cout, sum} = lo[H] ? {hi1, lo[H-1:0]} : {hi0, lo[H-1:0]};

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide unsigned add over WORDS cycles through one shared W-bit adder, LS word first.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int WORDS = DEF_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*WORDS-1:0] in_a,
  input  logic [W*WORDS-1:0] in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*WORDS-1:0] out_sum,
  output logic               out_cout,
  output logic               busy
);

  localparam int WW    = W * WORDS;
  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WW-1:0]    op_a_q, op_a_d;
  logic [WW-1:0]    op_b_q, op_b_d;
  logic [WW-1:0]    sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [W-1:0] word_a, word_b, add_sum;
  logic         add_cout;
  logic         accept;

  assign word_a = op_a_q[int'(idx_q)*W +: W];
  assign word_b = op_b_q[int'(idx_q)*W +: W];

  add32_cs #(.W(W)) u_add (
    .a    (word_a),
    .b    (word_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_ready  = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign out_valid = rst_n & (state_q == ST_DONE);
  assign busy      = rst_n & (state_q != ST_IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        sum_d[int'(idx_q)*W +: W] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST) begin
          cout_d  = add_cout;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Accept only happens from IDLE or DONE, so it never collides with a RUN word.
    if (accept) begin
      op_a_d  = in_a;
      op_b_d  = in_b;
      carry_d = in_cin;
      idx_d   = '0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench: directed table, backpressure/back-to-back/reset sequences, random vs. wide-add model.
module tb_wide_add_sequencer;

  localparam int W     = 32;
  localparam int WORDS = 4;
  localparam int WW    = W * WORDS;
  localparam int LAT   = WORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_cin;
  logic [WW-1:0] in_a, in_b;
  logic          out_valid, out_ready, out_cout, busy;
  logic [WW-1:0] out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.W(W), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  typedef struct {
    logic [WW-1:0] a;
    logic [WW-1:0] b;
    logic          cin;
    logic [WW-1:0] sum;
    logic          cout;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [WW:0] ref_add(input logic [WW-1:0] a, b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{WW{1'b0}}, cin};
  endfunction

  function automatic logic [WW-1:0] rnd_op();
    logic [WW-1:0] r;
    r = '0;
    for (int i = 0; i < WORDS; i++) begin
      case ($urandom_range(0, 3))
        0:       r[i*W +: W] = '1;
        1:       r[i*W +: W] = '0;
        default: r[i*W +: W] = $urandom;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [WW+2:0] act, input logic [WW+2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Present a request from IDLE, accept it and wait for the result.
  task automatic start_and_wait(input logic [WW-1:0] a, b, input logic cin, input string nm, output int n);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    chk({nm, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_cin = ~cin;
    wait_valid(n);
  endtask

  task automatic run_op(input logic [WW-1:0] a, b, input logic cin,
                        input logic [WW-1:0] esum, input logic ecout, input string nm);
    int n;
    start_and_wait(a, b, cin, nm, n);
    chk({nm, "_lat"}, n, LAT);
    chk({nm, "_res"}, {out_cout, out_sum}, {ecout, esum});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_idle"}, {out_valid, busy}, 0);
  endtask

  initial begin
    logic [WW-1:0] ra, rb, a2, b2;
    logic          rc, c2;
    logic [WW:0]   e, e2;
    int            n;

    vecs[0] = '{128'h0000_0001_FFFF_FFFF, 128'h1, 1'b0, 128'h0000_0002_0000_0000, 1'b0};
    vecs[1] = '{{WW{1'b1}}, '0, 1'b1, '0, 1'b1};
    vecs[2] = '{'0, '0, 1'b0, '0, 1'b0};
    vecs[3] = '{{WW{1'b1}}, {WW{1'b1}}, 1'b1, {WW{1'b1}}, 1'b1};
    vecs[4] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h8000_0000_0000_0000_0000_0000_0000_0000,
                1'b0, '0, 1'b1};
    vecs[5] = '{128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0,
                128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_cin = 1'b0; in_a = '0; in_b = '0;
    tick(); tick();
    chk("rst_outs", {in_ready, out_valid, busy}, 0);
    chk("rst_sum", {out_cout, out_sum}, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {in_ready, out_valid, busy}, 3'b100);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, $sformatf("vec%0d", i));

    // Backpressure: result held for 10 cycles, no accept while out_ready is low.
    ra = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    rb = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    e  = ref_add(ra, rb, 1'b1);
    start_and_wait(ra, rb, 1'b1, "bp", n);
    chk("bp_lat", n, LAT);
    in_valid = 1'b1; in_a = '1; in_b = '1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {out_valid, in_ready, out_cout, out_sum}, {2'b10, e});
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", {out_valid, busy}, 0);

    // Back-to-back: second accept on the DONE handshake cycle.
    ra = rnd_op(); rb = rnd_op(); rc = 1'b1;
    a2 = {WW{1'b1}}; b2 = 128'h1; c2 = 1'b0;
    e = ref_add(ra, rb, rc); e2 = ref_add(a2, b2, c2);
    in_a = ra; in_b = rb; in_cin = rc; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_a = a2; in_b = b2; in_cin = c2;
    wait_valid(n);
    chk("b2b_lat1", n, LAT);
    chk("b2b_res1", {out_cout, out_sum}, e);
    chk("b2b_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_nobubble", {out_valid, busy}, 2'b01);
    wait_valid(n);
    chk("b2b_lat2", n, LAT - 1 + 1);
    chk("b2b_res2", {out_cout, out_sum}, e2);
    tick();
    out_ready = 1'b0;
    chk("b2b_idle", {out_valid, busy}, 0);

    // Reset at idx=2 with a live carry; the next op must not inherit it.
    in_a = {WW{1'b1}}; in_b = 128'h1; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_outs", {busy, out_valid, in_ready}, 0);
    chk("midrst_sum", {out_cout, out_sum}, 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_stay_idle", {busy, out_valid}, 0);
    run_op('0, '0, 1'b0, '0, 1'b0, "post_midrst");
    run_op(128'h5, 128'h7, 1'b1, 128'hD, 1'b0, "post_midrst2");

    for (int i = 0; i < 1000; i++) begin
      ra = rnd_op(); rb = rnd_op(); rc = 1'($urandom_range(0, 1));
      e  = ref_add(ra, rb, rc);
      run_op(ra, rb, rc, e[WW-1:0], e[WW], "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
